// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin burst arbiter steering NUM_REQ producers onto one FIFO write port.
// Ports: clk, reset_n (async active-low); req/req_data from producers; grant (registered one-hot),
// accept (per-requester strobe); fifo_full in; fifo_write_en/fifo_wdata/fifo_wtag to the FIFO.
// Optional macro ARB_STATS_EN adds saturating counters stat_words and stat_stalls.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  localparam int TW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int BW = $clog2(BURST_LEN) + 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            accept,
  input  logic                          fifo_full,
  output logic                          fifo_write_en,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  output logic [TW-1:0]                 fifo_wtag
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]                   stat_words,
  output logic [15:0]                   stat_stalls
`endif
);
  typedef enum logic {IDLE, BURST} state_t;
  state_t             r_state, w_state_n;
  logic [NUM_REQ-1:0] r_grant, w_grant_n;
  logic [BW-1:0]      r_beat, w_beat_n;
  logic [TW-1:0]      r_last, w_last_n, w_g;
  logic               w_xfer, w_release;
  // Scan from farthest to nearest so the nearest pending requester after last wins; last itself is checked last.
  function automatic logic [NUM_REQ-1:0] rr(input logic [NUM_REQ-1:0] r, input logic [TW-1:0] last);
    logic [NUM_REQ-1:0] g;
    logic [TW-1:0]      idx;
    g = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = TW'((int'(last) + k) % NUM_REQ);
      if (r[idx]) g = NUM_REQ'(1) << idx;
    end
    return g;
  endfunction
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_beat  <= '0;
      r_last  <= TW'(NUM_REQ - 1);
    end else begin
      r_state <= w_state_n;
      r_grant <= w_grant_n;
      r_beat  <= w_beat_n;
      r_last  <= w_last_n;
    end
  always_comb begin
    w_g = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (r_grant[i]) w_g = TW'(i);
    w_xfer    = |(r_grant & req) & !fifo_full;
    w_release = (r_state == BURST) && ((w_xfer && r_beat == BW'(BURST_LEN - 1)) || !req[w_g]);
    w_state_n = r_state;
    w_grant_n = r_grant;
    w_beat_n  = r_beat;
    w_last_n  = r_last;
    if (r_state == IDLE) begin
      if (|req) begin
        w_state_n = BURST;
        w_grant_n = rr(req, r_last);
      end
    end else if (w_release) begin
      w_last_n  = w_g;
      w_beat_n  = '0;
      w_grant_n = |req ? rr(req, w_g) : '0;
      w_state_n = |req ? BURST : IDLE;
    end else begin
      w_beat_n = r_beat + {{(BW-1){1'b0}}, w_xfer};
    end
  end
  always_comb begin
    grant         = r_grant;
    accept        = r_grant & req & {NUM_REQ{!fifo_full}};
    fifo_write_en = |accept;
    fifo_wtag     = w_g;
    fifo_wdata    = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (r_grant[i]) fifo_wdata = fifo_wdata | req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end
`ifdef ARB_STATS_EN
  logic [15:0] r_words, r_stalls;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_words  <= '0;
      r_stalls <= '0;
    end else begin
      if (fifo_write_en && r_words != 16'hFFFF) r_words <= r_words + 16'd1;
      if (|(r_grant & req) && fifo_full && r_stalls != 16'hFFFF) r_stalls <= r_stalls + 16'd1;
    end
  assign stat_words  = r_words;
  assign stat_stalls = r_stalls;
`endif
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed table and sequence checks of fifo_write_arbiter.
module tb_fifo_write_arbiter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic        fifo_full = 1'b0;
  logic [3:0]  grant, accept;
  logic        fifo_write_en;
  logic [7:0]  fifo_wdata;
  logic [1:0]  fifo_wtag;
`ifdef ARB_STATS_EN
  logic [15:0] stat_words, stat_stalls;
`endif
  int errs = 0;
  int checks = 0;
  always #5 clk = ~clk;
  fifo_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BURST_LEN(4)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data), .grant(grant),
    .accept(accept), .fifo_full(fifo_full), .fifo_write_en(fifo_write_en),
    .fifo_wdata(fifo_wdata), .fifo_wtag(fifo_wtag)
`ifdef ARB_STATS_EN
    , .stat_words(stat_words), .stat_stalls(stat_stalls)
`endif
  );
  typedef struct {
    logic [3:0]  r;
    logic [31:0] d;
    logic        f;
    logic [3:0]  g;
    logic        we;
    logic [7:0]  wd;
    logic [1:0]  t;
  } vec_t;
  vec_t tbl[18];
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask
  task automatic expect_o(input string n, input logic [3:0] g, input logic we, input logic [7:0] wd, input logic [1:0] t);
    chk({n, " grant"}, 32'(grant), 32'(g));
    chk({n, " accept"}, 32'(accept), we ? 32'(g) : 32'd0);
    chk({n, " write_en"}, 32'(fifo_write_en), 32'(we));
    chk({n, " wdata"}, 32'(fifo_wdata), 32'(wd));
    chk({n, " wtag"}, 32'(fifo_wtag), 32'(t));
  endtask
  task automatic drive(input logic [3:0] r, input logic [31:0] d, input logic f);
    @(negedge clk);
    req = r;
    req_data = d;
    fifo_full = f;
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req = '0;
    fifo_full = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask
  initial begin
    // All requesters continuously: bursts of 4 rotate 0,1,2,3,0 with no gap.
    tbl[0] = '{r: 4'b1111, d: 32'hD3D2D1D0, f: 1'b0, g: 4'b0000, we: 1'b0, wd: 8'h00, t: 2'd0};
    for (int c = 1; c < 18; c++) begin
      int w;
      w = ((c - 1) / 4) % 4;
      tbl[c] = '{r: 4'b1111, d: 32'hD3D2D1D0, f: 1'b0, g: 4'(1 << w), we: 1'b1, wd: 8'(8'hD0 + w), t: 2'(w)};
    end
    do_reset();
    for (int c = 0; c < 18; c++) begin
      drive(tbl[c].r, tbl[c].d, tbl[c].f);
      expect_o($sformatf("rr[%0d]", c), tbl[c].g, tbl[c].we, tbl[c].wd, tbl[c].t);
    end
    // Single requester 1: 4 words, seamless re-grant, 2 more words, then release to IDLE.
    do_reset();
    drive(4'b0010, {16'h0, 8'hA1, 8'h0}, 1'b0);
    expect_o("single idle", 4'b0000, 1'b0, 8'h00, 2'd0);
    for (int k = 0; k < 6; k++) begin
      drive(4'b0010, {16'h0, 8'(8'hA1 + k), 8'h0}, 1'b0);
      expect_o($sformatf("single w%0d", k), 4'b0010, 1'b1, 8'(8'hA1 + k), 2'd1);
    end
    drive(4'b0000, {16'h0, 8'hA6, 8'h0}, 1'b0);
    expect_o("single drop", 4'b0010, 1'b0, 8'hA6, 2'd1);
    drive(4'b0000, {16'h0, 8'hA6, 8'h0}, 1'b0);
    expect_o("single end", 4'b0000, 1'b0, 8'h00, 2'd0);
    // Back-pressure on requester 2 after 2 beats.
    do_reset();
    drive(4'b0100, 32'h00C00000, 1'b0);
    expect_o("bp idle", 4'b0000, 1'b0, 8'h00, 2'd0);
    for (int k = 0; k < 2; k++) begin
      drive(4'b0100, 32'h00C00000, 1'b0);
      expect_o("bp pre", 4'b0100, 1'b1, 8'hC0, 2'd2);
    end
    for (int k = 0; k < 5; k++) begin
      drive(4'b0100, 32'h00C00000, 1'b1);
      expect_o($sformatf("bp full%0d", k), 4'b0100, 1'b0, 8'hC0, 2'd2);
    end
    for (int k = 0; k < 2; k++) begin
      drive(4'b0100, 32'h00C00000, 1'b0);
      expect_o("bp post", 4'b0100, 1'b1, 8'hC0, 2'd2);
    end
    drive(4'b0000, 32'h00C00000, 1'b0);
    expect_o("bp regrant", 4'b0100, 1'b0, 8'hC0, 2'd2);
`ifdef ARB_STATS_EN
    chk("stat_stalls", 32'(stat_stalls), 32'd5);
    chk("stat_words", 32'(stat_words), 32'd4);
`endif
    drive(4'b0000, 32'h00C00000, 1'b0);
    expect_o("bp end", 4'b0000, 1'b0, 8'h00, 2'd0);
    // Withdrawal: requester 0 drops after 1 beat, requester 3 takes over.
    do_reset();
    drive(4'b1001, 32'hE3000EE0, 1'b0);
    expect_o("wd idle", 4'b0000, 1'b0, 8'h00, 2'd0);
    drive(4'b1001, 32'hE3000EE0, 1'b0);
    expect_o("wd beat", 4'b0001, 1'b1, 8'hE0, 2'd0);
    drive(4'b1000, 32'hE3000EE0, 1'b0);
    expect_o("wd drop", 4'b0001, 1'b0, 8'hE0, 2'd0);
    drive(4'b1000, 32'hE3000EE0, 1'b0);
    expect_o("wd switch", 4'b1000, 1'b1, 8'hE3, 2'd3);
    // Asynchronous reset during requester 1's burst.
    do_reset();
    drive(4'b0010, 32'h0000B100, 1'b0);
    expect_o("ar idle", 4'b0000, 1'b0, 8'h00, 2'd0);
    drive(4'b0010, 32'h0000B100, 1'b0);
    expect_o("ar b1", 4'b0010, 1'b1, 8'hB1, 2'd1);
    drive(4'b0010, 32'h0000B100, 1'b0);
    expect_o("ar b2", 4'b0010, 1'b1, 8'hB1, 2'd1);
    reset_n = 1'b0;
    #1;
    expect_o("ar async", 4'b0000, 1'b0, 8'h00, 2'd0);
    @(negedge clk);
    reset_n = 1'b1;
    req = 4'b1010;
    req_data = 32'hB3000000 | 32'h0000B100;
    #1;
    expect_o("ar released", 4'b0000, 1'b0, 8'h00, 2'd0);
    drive(4'b1010, 32'hB300B100, 1'b0);
    expect_o("ar first", 4'b0010, 1'b1, 8'hB1, 2'd1);
`ifdef ARB_STATS_EN
    // Saturation of the word counter.
    do_reset();
    drive(4'b0001, 32'h0, 1'b0);
    repeat (70000) @(negedge clk);
    #1;
    chk("stat_words sat", 32'(stat_words), 32'hFFFF);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
Round-robin write-side arbiter that lets NUM_REQ producers share one synchronous FIFO's write port. It grants one requester at a time for a burst of up to BURST_LEN words and steers that requester's data onto the FIFO write interface. It honours FIFO full back-pressure and tags each written word with the source requester ID. It sits directly in front of the synchronous FIFO; the FIFO read side is untouched.

Parameters:
NUM_REQ, 4, number of requesters (legal 2..8)
DATA_WIDTH, 8, word width, must match the FIFO
BURST_LEN, 4, maximum words per grant before forced re-arbitration (>=1)

Ports:
clk  input  1  single clock, rising edge
reset_n  input  1  asynchronous, active-low reset
req  input  NUM_REQ  per-requester "word valid"; must hold with data stable until accepted or withdrawn
req_data  input  NUM_REQ*DATA_WIDTH  flat data bus, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
grant  output  NUM_REQ  registered one-hot (or zero) grant
accept  output  NUM_REQ  combinational per-requester acceptance strobe, = grant & req when fifo_full=0
fifo_full  input  1  FIFO full flag
fifo_write_en  output  1  FIFO write enable, = |accept
fifo_wdata  output  DATA_WIDTH  req_data slice of the granted requester; 0 when no grant
fifo_wtag  output  clog2(NUM_REQ)  index of the granted requester; 0 when no grant

Behaviour:
- Clock and reset: clk and reset_n; reset is asynchronous and active-low.
- Reset values: grant=0, state=IDLE, beat_cnt=0, last_winner=NUM_REQ-1. As a result, requester 0 wins the first arbitration.
- Effect of reset: all outputs derived from grant go to 0 immediately on reset assertion, not waiting for a clock edge.
- FSM states: IDLE and BURST.
- IDLE: grant=0. On a posedge with req!=0, grant <= RR winner and the state moves to BURST. Latency is 1 cycle from req to grant.
- RR winner: the first requester with req set, searching from last_winner+1 upward and wrapping modulo NUM_REQ. The search covers last_winner itself last.
- BURST, transfer rule: a word transfers in any cycle where req[g] & grant[g] & !fifo_full. On a transfer, beat_cnt increments.
- BURST, release condition: (transfer && beat_cnt==BURST_LEN-1) || !req[g].
- On release at a posedge:
  - last_winner <= g and beat_cnt <= 0.
  - If any req bit is set, grant <= RR winner computed with the updated last_winner, with no idle cycle. g may be re-granted only if no other requester is pending.
  - If no req bit is set, grant <= 0 and the state returns to IDLE.
- Full back-pressure: while fifo_full=1, accept=0 and fifo_write_en=0. beat_cnt holds and grant holds; there is no timeout.
- fifo_full asserting mid-burst: the burst resumes where it left off.
- Withdrawal: a requester dropping req mid-burst forfeits the rest of its burst. No word transfers in that cycle.
- Contract: the arbiter never issues fifo_write_en while fifo_full=1.
- Width rules: beat_cnt is clog2(BURST_LEN)+1 bits. Index arithmetic wraps modulo NUM_REQ, and non-power-of-2 NUM_REQ must wrap correctly.
- fifo_wdata and fifo_wtag are combinational muxes driven by the registered grant.

Optional Feature:
Macro ARB_STATS_EN.
- When defined, adds output ports stat_words[15:0] and stat_stalls[15:0]. Both are saturating counters that reset to 0 on reset_n.
- stat_words increments on every fifo_write_en.
- stat_stalls increments on every cycle with a grant active, req[g]=1 and fifo_full=1.
- When not defined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Single requester: req=4'b0010 with data 0xA1..0xA6 held per accept, fifo_full=0. Expect grant=0010 one cycle after req; 4 writes tagged 1. Then release and immediate re-grant to requester 1, since it is the only requester; the remaining 2 words are written.
- All requesting: req=4'b1111 continuously from reset. Expect grants in order 0,1,2,3,0, each for exactly 4 writes with no gap cycles. fifo_wtag sequence is 0000 1111 2222 3333.
- Back-pressure: during requester 2's burst after 2 beats, fifo_full=1 for 5 cycles. Expect fifo_write_en=0 and grant held for those 5 cycles, then exactly 2 more writes before release. With ARB_STATS_EN, stat_stalls=5.
- Withdrawal: requester 0 drops req after 1 beat while req[3]=1. Expect a grant switch to requester 3 at the next edge and no write in the drop cycle.
- Reset mid-burst: assert reset_n=0 asynchronously during beat 2 of requester 1. Expect grant=0 and fifo_write_en=0 before the next edge. After release with req=4'b1010, expect requester 1 granted first, because the winner restarts from index 0 upward.
- Saturation (ARB_STATS_EN): run 70000 writes. Expect stat_words to stick at 0xFFFF.
